hls_core_pkt_scheduler: RTL and testbench

Packet-level round-robin scheduler that shares one CE-domain processing core (an HLS kernel in a loopback-style pipe) between NUM_PORTS item streams inside an RFNoC block. It grants whole packets to the core and records each grant's port in a tag FIFO. It then routes the core's returned packets back to the originating output port, in order. It sits between the noc_shell item-stream ports and the core, and is configured by a per-port enable user register.

---
 rtl/hls_core_pkt_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_hls_core_pkt_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_core_pkt_scheduler.sv
// rtl/hls_core_pkt_scheduler.sv - packet-level round-robin scheduler sharing one core between item streams
// Tag FIFO remembers the source port of every granted packet so returns are routed back in order.

module hls_core_pkt_scheduler_tag_fifo #(
  parameter int W          = 1,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  input  logic                  pop,
  output logic [W-1:0]          pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [W-1:0]          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
endmodule

module hls_core_pkt_scheduler #(
  parameter int NUM_PORTS      = 2,
  parameter int ITEM_W         = 32,
  parameter int TAG_DEPTH_LOG2 = 3
) (
  input  logic                          ce_clk,
  input  logic                          ce_rst,
  input  logic [NUM_PORTS-1:0]          port_enable,
  input  logic [ITEM_W*NUM_PORTS-1:0]   s_in_tdata,
  input  logic [NUM_PORTS-1:0]          s_in_tlast,
  input  logic [NUM_PORTS-1:0]          s_in_tvalid,
  output logic [NUM_PORTS-1:0]          s_in_tready,
  output logic [ITEM_W-1:0]             m_core_tdata,
  output logic                          m_core_tlast,
  output logic                          m_core_tvalid,
  input  logic                          m_core_tready,
  input  logic [ITEM_W-1:0]             s_core_tdata,
  input  logic                          s_core_tlast,
  input  logic                          s_core_tvalid,
  output logic                          s_core_tready,
  output logic [ITEM_W*NUM_PORTS-1:0]   m_out_tdata,
  output logic [NUM_PORTS-1:0]          m_out_tlast,
  output logic [NUM_PORTS-1:0]          m_out_tvalid,
  input  logic [NUM_PORTS-1:0]          m_out_tready,
  output logic [TAG_DEPTH_LOG2:0]       outstanding,
  output logic                          busy
);
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state, state_next;
  logic [GW-1:0]     grant, grant_next;
  logic [GW-1:0]     last_grant, last_grant_next;
  logic [GW-1:0]     sel_port, cand;
  logic              sel_valid;
  logic [NUM_PORTS-1:0] request;

  logic              tag_push, tag_pop, tag_full, tag_empty;
  logic [GW-1:0]     head;
  logic [TAG_DEPTH_LOG2:0] tag_count;

  assign request = s_in_tvalid & port_enable;

  // Walk downward so the lowest offset from last_grant wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_port  = '0;
    cand      = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = GW'((int'(last_grant) + k) % NUM_PORTS);
      if (request[cand]) begin
        sel_valid = 1'b1;
        sel_port  = cand;
      end
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_PORTS - 1);
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    tag_push        = 1'b0;
    s_in_tready     = '0;
    m_core_tdata    = s_in_tdata[ITEM_W*int'(grant) +: ITEM_W];
    m_core_tlast    = 1'b0;
    m_core_tvalid   = 1'b0;
    busy            = 1'b0;
    case (state)
      IDLE: begin
        if (sel_valid && !tag_full) begin
          grant_next = sel_port;
          tag_push   = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        busy               = 1'b1;
        m_core_tlast       = s_in_tlast[grant];
        m_core_tvalid      = s_in_tvalid[grant];
        s_in_tready[grant] = m_core_tready;
        if (s_in_tvalid[grant] && m_core_tready && s_in_tlast[grant]) begin
          last_grant_next = grant;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  hls_core_pkt_scheduler_tag_fifo #(
    .W          (GW),
    .DEPTH_LOG2 (TAG_DEPTH_LOG2)
  ) u_tag_fifo (
    .clk       (ce_clk),
    .rst       (ce_rst),
    .push      (tag_push),
    .push_data (grant_next),
    .pop       (tag_pop),
    .pop_data  (head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  // Data fans out to every port; only valid/last are steered by the head tag.
  always_comb begin
    m_out_tvalid  = '0;
    m_out_tlast   = '0;
    s_core_tready = 1'b0;
    if (!tag_empty) begin
      m_out_tvalid[head] = s_core_tvalid;
      m_out_tlast[head]  = s_core_tlast;
      s_core_tready      = m_out_tready[head];
    end
  end

  assign m_out_tdata = {NUM_PORTS{s_core_tdata}};
  assign tag_pop     = s_core_tvalid & s_core_tready & s_core_tlast;
  assign outstanding = tag_count;
endmodule

// File: tb/tb_hls_core_pkt_scheduler.sv
// tb/tb_hls_core_pkt_scheduler.sv - directed bench for hls_core_pkt_scheduler
module tb_hls_core_pkt_scheduler;
  logic        ce_clk = 1'b0;
  logic        ce_rst = 1'b1;
  logic [1:0]  port_enable = 2'b11;
  logic [63:0] s_in_tdata = '0;
  logic [1:0]  s_in_tlast = '0;
  logic [1:0]  s_in_tvalid = '0;
  logic [1:0]  s_in_tready;
  logic [31:0] m_core_tdata;
  logic        m_core_tlast, m_core_tvalid;
  logic        m_core_tready = 1'b1;
  logic [31:0] s_core_tdata = '0;
  logic        s_core_tlast = 1'b0;
  logic        s_core_tvalid = 1'b0;
  logic        s_core_tready;
  logic [63:0] m_out_tdata;
  logic [1:0]  m_out_tlast, m_out_tvalid;
  logic [1:0]  m_out_tready = 2'b11;
  logic [3:0]  outstanding;
  logic        busy;

  hls_core_pkt_scheduler #(.NUM_PORTS(2), .ITEM_W(32), .TAG_DEPTH_LOG2(3)) dut (
    .ce_clk(ce_clk), .ce_rst(ce_rst), .port_enable(port_enable),
    .s_in_tdata(s_in_tdata), .s_in_tlast(s_in_tlast), .s_in_tvalid(s_in_tvalid), .s_in_tready(s_in_tready),
    .m_core_tdata(m_core_tdata), .m_core_tlast(m_core_tlast), .m_core_tvalid(m_core_tvalid), .m_core_tready(m_core_tready),
    .s_core_tdata(s_core_tdata), .s_core_tlast(s_core_tlast), .s_core_tvalid(s_core_tvalid), .s_core_tready(s_core_tready),
    .m_out_tdata(m_out_tdata), .m_out_tlast(m_out_tlast), .m_out_tvalid(m_out_tvalid), .m_out_tready(m_out_tready),
    .outstanding(outstanding), .busy(busy)
  );

  always #5 ce_clk = ~ce_clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] src_q0[$];
  logic [32:0] src_q1[$];
  logic [32:0] core_q[$];
  logic [32:0] in_log[$];
  logic [32:0] out_q0[$];
  logic [32:0] out_q1[$];
  int          grant_log[$];
  int          ret_log[$];
  int          gap_log[$];
  bit          stall = 1'b0;

  logic [1:0]  src_hs = '0;
  logic        core_in_hs = 1'b0, core_out_hs = 1'b0;
  logic [32:0] core_in_d = '0;
  int          cyc = 0, last_tlast_cyc = 0;
  bit          have_last = 1'b0, first_of_pkt = 1'b1;

  // Handshakes are sampled mid-cycle, then acted on at the following rising edge.
  always @(negedge ce_clk) begin
    cyc++;
    src_hs      = s_in_tvalid & s_in_tready;
    core_in_hs  = m_core_tvalid & m_core_tready;
    core_in_d   = {m_core_tlast, m_core_tdata};
    core_out_hs = s_core_tvalid & s_core_tready;
    if (!ce_rst) begin
      if (core_in_hs) begin
        in_log.push_back(core_in_d);
        if (first_of_pkt && have_last) gap_log.push_back(cyc - last_tlast_cyc);
        first_of_pkt = m_core_tlast;
        if (m_core_tlast) begin
          grant_log.push_back(s_in_tready[1] ? 1 : 0);
          last_tlast_cyc = cyc;
          have_last = 1'b1;
        end
      end
      if (m_out_tvalid[0] && m_out_tready[0]) begin
        out_q0.push_back({m_out_tlast[0], m_out_tdata[31:0]});
        if (m_out_tlast[0]) ret_log.push_back(0);
      end
      if (m_out_tvalid[1] && m_out_tready[1]) begin
        out_q1.push_back({m_out_tlast[1], m_out_tdata[63:32]});
        if (m_out_tlast[1]) ret_log.push_back(1);
      end
    end
  end

  always @(posedge ce_clk) begin
    logic [32:0] h0, h1, hc;
    if (ce_rst) begin
      src_q0.delete();
      src_q1.delete();
      core_q.delete();
    end else begin
      if (src_hs[0]) void'(src_q0.pop_front());
      if (src_hs[1]) void'(src_q1.pop_front());
      if (core_out_hs) void'(core_q.pop_front());
      if (core_in_hs) core_q.push_back(core_in_d);
    end
    h0 = (src_q0.size() != 0) ? src_q0[0] : 33'h0;
    h1 = (src_q1.size() != 0) ? src_q1[0] : 33'h0;
    hc = (core_q.size() != 0) ? core_q[0] : 33'h0;
    s_in_tvalid   <= {src_q1.size() != 0, src_q0.size() != 0};
    s_in_tlast    <= {h1[32], h0[32]};
    s_in_tdata    <= {h1[31:0], h0[31:0]};
    s_core_tvalid <= (core_q.size() != 0) && !stall;
    s_core_tlast  <= hc[32];
    s_core_tdata  <= hc[31:0];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] item(input bit last, input int d);
    return {31'b0, last, d[31:0]};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ce_clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    in_log.delete(); out_q0.delete(); out_q1.delete();
    grant_log.delete(); ret_log.delete(); gap_log.delete();
    have_last = 1'b0;
    first_of_pkt = 1'b1;
  endtask

  task automatic do_reset();
    ce_rst = 1'b1;
    tick(2);
    ce_rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!busy && n < 200) begin
      tick(1);
      n++;
    end
    check(tag, busy, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((src_q0.size() != 0 || src_q1.size() != 0 || core_q.size() != 0 ||
            outstanding != 0 || busy) && n < 3000) begin
      tick(1);
      n++;
    end
    check(tag, n >= 3000, 0);
  endtask

  initial begin
    logic [32:0] v;
    int cnt;

    // Reset state
    ce_rst = 1'b1;
    tick(3);
    check("rst s_in_tready", s_in_tready, 0);
    check("rst m_core_tvalid", m_core_tvalid, 0);
    check("rst s_core_tready", s_core_tready, 0);
    check("rst m_out_tvalid", m_out_tvalid, 0);
    check("rst outstanding", outstanding, 0);
    check("rst busy", busy, 0);
    ce_rst = 1'b0;
    clear_logs();

    // 1: single 4-item packet through a registered loopback
    for (int j = 0; j < 4; j++) src_q0.push_back({j == 3, 32'(32'h11 + j)});
    wait_busy("t1 busy");
    check("t1 outstanding at grant", outstanding, 1);
    wait_idle("t1 idle");
    check("t1 out0 count", out_q0.size(), 4);
    check("t1 out1 count", out_q1.size(), 0);
    for (int j = 0; j < 4; j++) begin
      v = (out_q0.size() > j) ? out_q0[j] : 33'h0;
      check("t1 out0 item", {31'b0, v}, item(j == 3, 32'h11 + j));
    end
    check("t1 outstanding final", outstanding, 0);

    // 2: both ports busy, 3 packets each
    do_reset();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++) begin
        src_q0.push_back({j == 2, 32'(k * 16 + j)});
        src_q1.push_back({j == 2, 32'(256 + k * 16 + j)});
      end
    wait_idle("t2 idle");
    check("t2 grant count", grant_log.size(), 6);
    check("t2 return count", ret_log.size(), 6);
    for (int p = 0; p < 6; p++) begin
      check("t2 grant order", (grant_log.size() > p) ? grant_log[p] : -1, p % 2);
      check("t2 return order", (ret_log.size() > p) ? ret_log[p] : -1, p % 2);
    end
    check("t2 gap count", gap_log.size(), 5);
    for (int p = 0; p < 5; p++)
      check("t2 gap cycles", (gap_log.size() > p) ? gap_log[p] : -1, 2);
    check("t2 out0 count", out_q0.size(), 9);
    check("t2 out1 count", out_q1.size(), 9);
    for (int i = 0; i < 9; i++) begin
      v = (out_q1.size() > i) ? out_q1[i] : 33'h0;
      check("t2 out1 item", {31'b0, v}, item((i % 3) == 2, 256 + (i / 3) * 16 + (i % 3)));
    end

    // 3: port 0 masked by enable
    do_reset();
    port_enable = 2'b10;
    src_q0.push_back({1'b0, 32'h30});
    src_q0.push_back({1'b1, 32'h31});
    for (int j = 0; j < 3; j++) src_q1.push_back({j == 2, 32'(32'h40 + j)});
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (s_in_tready[0]) cnt++;
    end
    check("t3 tready0 while masked", cnt, 0);
    check("t3 grants while masked", grant_log.size(), 1);
    check("t3 first grant", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
    port_enable = 2'b11;
    wait_idle("t3 idle");
    check("t3 grants after enable", grant_log.size(), 2);
    check("t3 second grant", (grant_log.size() > 1) ? grant_log[1] : -1, 0);
    check("t3 out0 count", out_q0.size(), 2);

    // 4: tag FIFO fills while returns stall
    do_reset();
    stall = 1'b1;
    for (int j = 0; j < 9; j++) src_q0.push_back({1'b1, 32'(32'h50 + j)});
    tick(40);
    check("t4 outstanding full", outstanding, 8);
    check("t4 grants full", grant_log.size(), 8);
    check("t4 ninth held", src_q0.size(), 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (s_in_tready[0] || busy) cnt++;
    end
    check("t4 held while full", cnt, 0);
    stall = 1'b0;
    tick(1);
    stall = 1'b1;
    tick(1);
    check("t4 outstanding after one return", outstanding, 7);
    check("t4 not yet granted", busy, 0);
    tick(1);
    check("t4 ninth granted", busy, 1);
    check("t4 outstanding refilled", outstanding, 8);
    stall = 1'b0;
    wait_idle("t4 idle");
    check("t4 returns", ret_log.size(), 9);
    check("t4 out0 count", out_q0.size(), 9);

    // 5: enable dropped mid-packet
    do_reset();
    for (int j = 0; j < 5; j++) src_q0.push_back({j == 4, 32'(32'h60 + j)});
    wait_busy("t5 busy");
    tick(1);
    port_enable = 2'b10;
    src_q0.push_back({1'b0, 32'h70});
    src_q0.push_back({1'b1, 32'h71});
    tick(30);
    check("t5 core items", in_log.size(), 5);
    check("t5 core item 2", {31'b0, (in_log.size() > 1) ? in_log[1] : 33'h0}, item(0, 32'h61));
    check("t5 core tlast item", {31'b0, (in_log.size() > 4) ? in_log[4] : 33'h0}, item(1, 32'h64));
    check("t5 grants", grant_log.size(), 1);
    check("t5 out0 count", out_q0.size(), 5);
    check("t5 next packet held", src_q0.size(), 2);
    check("t5 tready0 low", s_in_tready[0], 0);

    // 6: reset with three packets in flight
    do_reset();
    port_enable = 2'b11;
    stall = 1'b1;
    src_q0.push_back({1'b0, 32'h80}); src_q0.push_back({1'b1, 32'h81});
    src_q0.push_back({1'b0, 32'h84}); src_q0.push_back({1'b1, 32'h85});
    src_q1.push_back({1'b0, 32'h82}); src_q1.push_back({1'b1, 32'h83});
    cnt = 0;
    while (outstanding != 3 && cnt < 200) begin
      tick(1);
      cnt++;
    end
    check("t6 reached three in flight", outstanding, 3);
    check("t6 mid packet", busy, 1);
    ce_rst = 1'b1;
    tick(1);
    check("t6 s_in_tready", s_in_tready, 0);
    check("t6 m_core_tvalid", m_core_tvalid, 0);
    check("t6 s_core_tready", s_core_tready, 0);
    check("t6 m_out_tvalid", m_out_tvalid, 0);
    check("t6 outstanding", outstanding, 0);
    check("t6 busy", busy, 0);
    ce_rst = 1'b0;
    stall = 1'b0;
    clear_logs();
    src_q0.push_back({1'b1, 32'h90});
    src_q1.push_back({1'b1, 32'h91});
    wait_idle("t6 idle");
    check("t6 grants after reset", grant_log.size(), 2);
    check("t6 first grant after reset", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    check("t6 out0 item", {31'b0, (out_q0.size() > 0) ? out_q0[0] : 33'h0}, item(1, 32'h90));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
